// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions: decode class codes, FSM encoding, register index.
// Imported by decode control and the hazard controller.
package pipe_pkg;

  localparam logic [5:0] CLS_INVALID  = 6'd0;
  localparam logic [5:0] CLS_SHIFT    = 6'd1;
  localparam logic [5:0] CLS_ADD_SUB  = 6'd2;
  localparam logic [5:0] CLS_MOVE_C   = 6'd3;
  localparam logic [5:0] CLS_ALU      = 6'd4;
  localparam logic [5:0] CLS_LD_SR    = 6'd7;
  localparam logic [5:0] CLS_IMM_LDSR = 6'd9;
  localparam logic [5:0] CLS_LD_SR_B  = 6'd10;
  localparam logic [5:0] CLS_SP       = 6'd11;
  localparam logic [5:0] CLS_LD_A     = 6'd12;
  localparam logic [5:0] CLS_COND_B   = 6'd16;
  localparam logic [5:0] CLS_UNCOND_B = 6'd18;

  typedef logic [2:0] reg_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    BR_PEND  = 2'd2,
    ERR      = 2'd3
  } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller bundle: decode/stage status in, stage controls and stats out.
// CNT_W sizes the performance counters and must match the controller.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  import pipe_pkg::*;

  logic             id_valid;
  logic [5:0]       id_class;
  reg_t             id_rs;
  reg_t             id_rt;
  logic             id_rs_used;
  logic             id_rt_used;
  logic             ex_valid;
  logic             ex_wr;
  logic             ex_is_load;
  reg_t             ex_rd;
  logic             mem_valid;
  logic             mem_wr;
  logic             mem_req;
  reg_t             mem_rd;
  logic             br_taken;
  logic             dmem_ready;

  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             wait_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [1:0]       state;

  modport master (
    output id_valid, id_class, id_rs, id_rt, id_rs_used, id_rt_used,
    output ex_valid, ex_wr, ex_is_load, ex_rd,
    output mem_valid, mem_wr, mem_req, mem_rd,
    output br_taken, dmem_ready,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    input  ifid_flush, idex_bubble, wait_timeout,
    input  stall_cnt, flush_cnt, state
  );

  modport slave (
    input  id_valid, id_class, id_rs, id_rt, id_rs_used, id_rt_used,
    input  ex_valid, ex_wr, ex_is_load, ex_rd,
    input  mem_valid, mem_wr, mem_req, mem_rd,
    input  br_taken, dmem_ready,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    output ifid_flush, idex_bubble, wait_timeout,
    output stall_cnt, flush_cnt, state
  );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// Source/destination comparator raising haz for the ID instruction.
// FWD=1: only load-use; FWD=0: any writing producer in EX or MEM.
module hazard_cmp
  import pipe_pkg::*;
#(
  parameter bit FWD = 1'b0
) (
  input  logic       id_valid,
  input  logic [5:0] id_class,
  input  reg_t       id_rs,
  input  reg_t       id_rt,
  input  logic       id_rs_used,
  input  logic       id_rt_used,
  input  logic       ex_valid,
  input  logic       ex_wr,
  input  logic       ex_is_load,
  input  reg_t       ex_rd,
  input  logic       mem_valid,
  input  logic       mem_wr,
  input  reg_t       mem_rd,
  output logic       haz
);

  logic ex_hit;
  logic mem_hit;
  logic rs_hit;
  logic rt_hit;

  assign ex_hit  = ex_valid & ex_wr & (ex_is_load | ~FWD);
  assign mem_hit = mem_valid & mem_wr & ~FWD;

  assign rs_hit = id_rs_used &
                  ((ex_hit & (ex_rd == id_rs)) |
                   (mem_hit & (mem_rd == id_rs)));
  assign rt_hit = id_rt_used &
                  ((ex_hit & (ex_rd == id_rt)) |
                   (mem_hit & (mem_rd == id_rt)));

  assign haz = id_valid & (id_class != CLS_INVALID) & (rs_hit | rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: stage enables, flush/bubble, stall stats.
// Define FORWARD_EN when the EX/MEM forwarding network is present.
module pipe_hazard_ctrl #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_hazard_ctrl_if.slave bus
);
  import pipe_pkg::*;

  localparam int WW = $clog2(WAIT_MAX + 1);
`ifdef FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  state_t           st, st_n;
  logic             br_pend, br_pend_n;
  logic [WW-1:0]    wcnt, wcnt_n;
  logic             wt, wt_n;
  logic             boot;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  logic haz;
  logic mw;
  logic run;
  logic br;
  logic fe_en;
  logic be_en;
  logic flush;
  logic bubble;

  hazard_cmp #(.FWD(FWD)) u_cmp (
    .id_valid   (bus.id_valid),
    .id_class   (bus.id_class),
    .id_rs      (bus.id_rs),
    .id_rt      (bus.id_rt),
    .id_rs_used (bus.id_rs_used),
    .id_rt_used (bus.id_rt_used),
    .ex_valid   (bus.ex_valid),
    .ex_wr      (bus.ex_wr),
    .ex_is_load (bus.ex_is_load),
    .ex_rd      (bus.ex_rd),
    .mem_valid  (bus.mem_valid),
    .mem_wr     (bus.mem_wr),
    .mem_rd     (bus.mem_rd),
    .haz        (haz)
  );

  assign mw = bus.mem_valid & bus.mem_req & ~bus.dmem_ready;

  always_comb begin
    st_n      = st;
    br_pend_n = br_pend;
    wcnt_n    = wcnt;
    wt_n      = wt;
    run       = 1'b0;
    br        = 1'b0;
    fe_en     = 1'b1;
    be_en     = 1'b1;
    flush     = 1'b0;
    bubble    = 1'b0;
    // boot covers reset and the first cycle after release
    if (!boot) begin
      unique case (st)
        ERR: begin
          fe_en = 1'b0;
          be_en = 1'b0;
        end
        MEM_WAIT: begin
          if (bus.dmem_ready) begin
            run  = 1'b1;
            br   = bus.br_taken;
            st_n = br_pend ? BR_PEND : RUN;
          end else begin
            fe_en  = 1'b0;
            be_en  = 1'b0;
            wcnt_n = wcnt + WW'(1);
            if (wcnt == WW'(WAIT_MAX - 1)) begin
              st_n = ERR;
              wt_n = 1'b1;
            end
          end
        end
        default: begin
          run  = 1'b1;
          br   = bus.br_taken | (st == BR_PEND);
          st_n = RUN;
        end
      endcase
      if (run) begin
        if (mw) begin
          fe_en     = 1'b0;
          be_en     = 1'b0;
          st_n      = MEM_WAIT;
          wcnt_n    = '0;
          br_pend_n = br_pend | bus.br_taken;
        end else if (br) begin
          flush     = 1'b1;
          bubble    = 1'b1;
          br_pend_n = 1'b0;
        end else if (haz) begin
          fe_en  = 1'b0;
          bubble = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= RUN;
      br_pend <= 1'b0;
      wcnt    <= '0;
      wt      <= 1'b0;
      boot    <= 1'b1;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      st      <= st_n;
      br_pend <= br_pend_n;
      wcnt    <= wcnt_n;
      wt      <= wt_n;
      boot    <= 1'b0;
      if (!fe_en && stall_q != '1)
        stall_q <= stall_q + CNT_W'(1);
      if (flush && flush_q != '1)
        flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign bus.pc_en        = fe_en;
  assign bus.ifid_en      = fe_en;
  assign bus.idex_en      = be_en;
  assign bus.exmem_en     = be_en;
  assign bus.memwb_en     = be_en;
  assign bus.ifid_flush   = flush;
  assign bus.idex_bubble  = bubble;
  assign bus.wait_timeout = wt;
  assign bus.stall_cnt    = stall_q;
  assign bus.flush_cnt    = flush_q;
  assign bus.state        = st;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a 16-bit-counter instance plus a
// 4-bit-counter instance sharing the same stimulus for saturation.
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;

`ifdef FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   base;

  pipe_hazard_ctrl_if #(.CNT_W(16)) a ();
  pipe_hazard_ctrl_if #(.CNT_W(4))  s ();

  pipe_hazard_ctrl #(.WAIT_MAX(15), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a)
  );

  pipe_hazard_ctrl #(.WAIT_MAX(15), .CNT_W(4)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (s)
  );

  assign s.id_valid   = a.id_valid;
  assign s.id_class   = a.id_class;
  assign s.id_rs      = a.id_rs;
  assign s.id_rt      = a.id_rt;
  assign s.id_rs_used = a.id_rs_used;
  assign s.id_rt_used = a.id_rt_used;
  assign s.ex_valid   = a.ex_valid;
  assign s.ex_wr      = a.ex_wr;
  assign s.ex_is_load = a.ex_is_load;
  assign s.ex_rd      = a.ex_rd;
  assign s.mem_valid  = a.mem_valid;
  assign s.mem_wr     = a.mem_wr;
  assign s.mem_req    = a.mem_req;
  assign s.mem_rd     = a.mem_rd;
  assign s.br_taken   = a.br_taken;
  assign s.dmem_ready = a.dmem_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    a.id_valid   = 1'b0;
    a.id_class   = CLS_INVALID;
    a.id_rs      = 3'd0;
    a.id_rt      = 3'd0;
    a.id_rs_used = 1'b0;
    a.id_rt_used = 1'b0;
    a.ex_valid   = 1'b0;
    a.ex_wr      = 1'b0;
    a.ex_is_load = 1'b0;
    a.ex_rd      = 3'd0;
    a.mem_valid  = 1'b0;
    a.mem_wr     = 1'b0;
    a.mem_req    = 1'b0;
    a.mem_rd     = 3'd0;
    a.br_taken   = 1'b0;
    a.dmem_ready = 1'b1;
  endtask

  task automatic load_use();
    a.ex_valid   = 1'b1;
    a.ex_wr      = 1'b1;
    a.ex_is_load = 1'b1;
    a.ex_rd      = 3'd3;
    a.id_valid   = 1'b1;
    a.id_class   = CLS_ALU;
    a.id_rs      = 3'd3;
    a.id_rs_used = 1'b1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle();
    load_use();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_pc_en", a.pc_en, 1);
    chk("rst_bubble", a.idex_bubble, 0);
    chk("rst_flush", a.ifid_flush, 0);
    chk("rst_state", a.state, 0);
    chk("rst_stall", a.stall_cnt, 0);
    chk("rst_wt", a.wait_timeout, 0);

    rst_n = 1'b1;
    #1;
    chk("boot_pc_en", a.pc_en, 1);
    chk("boot_bubble", a.idex_bubble, 0);
    cyc();
    chk("boot_stall", a.stall_cnt, 0);

    #1;
    chk("lu_pc_en", a.pc_en, 0);
    chk("lu_ifid_en", a.ifid_en, 0);
    chk("lu_bubble", a.idex_bubble, 1);
    chk("lu_idex_en", a.idex_en, 1);
    chk("lu_exmem_en", a.exmem_en, 1);
    chk("lu_memwb_en", a.memwb_en, 1);
    cyc();
    chk("lu_stall", a.stall_cnt, 1);
    a.ex_valid = 1'b0;
    #1;
    chk("lu_next_pc_en", a.pc_en, 1);
    chk("lu_next_bubble", a.idex_bubble, 0);
    cyc();
    chk("lu_next_stall", a.stall_cnt, 1);

    idle();
    load_use();
    a.id_class = CLS_INVALID;
    #1;
    chk("inv_pc_en", a.pc_en, 1);
    a.id_class   = CLS_LD_A;
    a.id_rs_used = 1'b0;
    #1;
    chk("unused_pc_en", a.pc_en, 1);
    cyc();

    idle();
    load_use();
    a.br_taken = 1'b1;
    #1;
    chk("bh_flush", a.ifid_flush, 1);
    chk("bh_bubble", a.idex_bubble, 1);
    chk("bh_pc_en", a.pc_en, 1);
    chk("bh_ifid_en", a.ifid_en, 1);
    cyc();
    chk("bh_flush_cnt", a.flush_cnt, 1);
    chk("bh_stall_cnt", a.stall_cnt, 1);
    chk("bh_state", a.state, 0);

    idle();
    a.mem_valid  = 1'b1;
    a.mem_req    = 1'b1;
    a.dmem_ready = 1'b0;
    a.br_taken   = 1'b1;
    #1;
    chk("mw1_pc_en", a.pc_en, 0);
    chk("mw1_memwb_en", a.memwb_en, 0);
    chk("mw1_flush", a.ifid_flush, 0);
    cyc();
    chk("mw1_state", a.state, 1);
    a.br_taken = 1'b0;
    #1;
    chk("mw2_idex_en", a.idex_en, 0);
    cyc();
    #1;
    chk("mw3_pc_en", a.pc_en, 0);
    cyc();
    chk("mw_stall", a.stall_cnt, 4);
    a.dmem_ready = 1'b1;
    #1;
    chk("mwr_pc_en", a.pc_en, 1);
    chk("mwr_flush", a.ifid_flush, 0);
    cyc();
    chk("mwr_state", a.state, 2);
    a.mem_valid = 1'b0;
    #1;
    chk("bp_flush", a.ifid_flush, 1);
    chk("bp_pc_en", a.pc_en, 1);
    cyc();
    chk("bp_state", a.state, 0);
    chk("bp_flush_cnt", a.flush_cnt, 2);
    chk("bp_stall", a.stall_cnt, 4);
    #1;
    chk("bp_after_flush", a.ifid_flush, 0);

    a.mem_valid = 1'b1;
    a.dmem_ready = 1'b1;
    #1;
    chk("nowait_pc_en", a.pc_en, 1);
    cyc();
    chk("nowait_state", a.state, 0);

    idle();
    a.ex_valid   = 1'b1;
    a.ex_wr      = 1'b1;
    a.ex_rd      = 3'd5;
    a.id_valid   = 1'b1;
    a.id_class   = CLS_ADD_SUB;
    a.id_rt      = 3'd5;
    a.id_rt_used = 1'b1;
    #1;
    chk("raw_ex_pc_en", a.pc_en, FWD ? 1 : 0);
    cyc();
    a.ex_valid  = 1'b0;
    a.mem_valid = 1'b1;
    a.mem_wr    = 1'b1;
    a.mem_rd    = 3'd5;
    #1;
    chk("raw_mem_pc_en", a.pc_en, FWD ? 1 : 0);
    cyc();
    a.mem_valid = 1'b0;
    #1;
    chk("raw_wb_pc_en", a.pc_en, 1);
    cyc();
    chk("raw_stall", a.stall_cnt, FWD ? 4 : 6);

    base = FWD ? 4 : 6;
    idle();
    load_use();
    repeat (20) cyc();
    chk("sat16_stall", a.stall_cnt, base + 20);
    chk("sat4_stall", s.stall_cnt, 15);
    chk("sat4_flush", s.flush_cnt, 2);

    idle();
    a.mem_valid  = 1'b1;
    a.mem_req    = 1'b1;
    a.dmem_ready = 1'b0;
    cyc();
    repeat (14) cyc();
    chk("to_pre_state", a.state, 1);
    chk("to_pre_wt", a.wait_timeout, 0);
    cyc();
    chk("to_state", a.state, 3);
    chk("to_wt", a.wait_timeout, 1);
    a.dmem_ready = 1'b1;
    #1;
    chk("err_pc_en", a.pc_en, 0);
    chk("err_memwb_en", a.memwb_en, 0);
    cyc();
    chk("err_hold", a.state, 3);

    rst_n = 1'b0;
    #2;
    chk("rr_state", a.state, 0);
    chk("rr_wt", a.wait_timeout, 0);
    chk("rr_stall", a.stall_cnt, 0);
    chk("rr_flush", a.flush_cnt, 0);
    chk("rr_pc_en", a.pc_en, 1);
    rst_n = 1'b1;
    idle();
    repeat (2) cyc();
    chk("post_state", a.state, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
